// File: rtl/io_port_pkg.sv
// Shared types and constants for the external I/O interrupt port.
package io_port_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HOLD_W = 4;
  localparam logic [BYTE_W-1:0] DATA_IDLE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } irq_state_e;

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with show-ahead head: storage, wrapping pointers, saturating occupancy.
module io_byte_fifo
  import io_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [BYTE_W-1:0]        rd_data_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt_c,
  output logic                     full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Pops on empty are ignored; a push into a full FIFO only lands alongside a pop.
  always_comb begin
    full_c = (count == CNT_W'(DEPTH));
    do_rd  = rd_en && (count != '0);
    do_wr  = wr_en && (!full_c || do_rd);
    count_nxt_c = count;
    if (do_wr && !do_rd) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Head byte straight from storage, idle pattern when empty.
  always_comb begin
    rd_data_c = (count == '0) ? DATA_IDLE : mem[rd_ptr];
  end

  // Pointer and occupancy registers; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
    end
  end

  // Storage array; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/io_irq_port.sv
// External-side I/O port for the CPU: byte FIFO feeding data_in, interrupt FSM
// with post-read holdoff, and a latched CPU output byte.
// Build option: define IO_IRQ_PORT_OVERFLOW_EN to always accept ext_data and
// flag dropped bytes on a sticky overflow bit instead of back-pressuring.
module io_irq_port
  import io_port_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             ext_data,
  input  logic                   ext_valid,
  output logic                   ext_ready,
  output logic [7:0]             data_in,
  output logic                   interrupt,
  input  logic                   cpu_rd,
  input  logic [7:0]             data_out,
  input  logic                   cpu_wr,
  output logic [7:0]             out_data,
  output logic                   out_stb,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   cpu_clr_ovf
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  irq_state_e        state_q;
  irq_state_e        state_nxt;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_nxt;
  logic              irq_d;
  logic [CNT_W-1:0]  count_nxt;
  logic              full;
  logic              fifo_wr;

  io_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (fifo_wr),
    .wr_data     (ext_data),
    .rd_en       (cpu_rd),
    .rd_data_c   (data_in),
    .count       (count),
    .count_nxt_c (count_nxt),
    .full_c      (full)
  );

`ifdef IO_IRQ_PORT_OVERFLOW_EN
  logic drop;

  // Always ready; a push into a full FIFO with no pop is discarded.
  assign ext_ready = 1'b1;
  assign fifo_wr   = ext_valid;
  assign drop      = ext_valid && full && !cpu_rd;

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (cpu_clr_ovf) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;

  // Back-pressure when full unless the CPU frees a slot this cycle.
  assign ext_ready      = (count != CNT_W'(DEPTH)) || cpu_rd;
  assign fifo_wr        = ext_valid && ext_ready;
  assign overflow       = 1'b0;
  assign unused_clr_ovf = cpu_clr_ovf;
`endif

  // IRQ state and holdoff counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // Next-state: pending while data waits, quiet for HOLDOFF cycles after each read.
  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_q;
    case (state_q)
      IDLE: begin
        if (count_nxt != '0) state_nxt = PEND;
      end
      PEND: begin
        if (cpu_rd) begin
          if (HOLDOFF == 0) begin
            state_nxt = (count_nxt != '0) ? PEND : IDLE;
          end else begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_W'(HOLDOFF);
          end
        end
      end
      HOLD: begin
        if (hold_q <= HOLD_W'(1)) begin
          hold_nxt  = '0;
          state_nxt = (count_nxt != '0) ? PEND : IDLE;
        end else begin
          hold_nxt = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // Output decode: request level follows the pending state.
  always_comb begin
    irq_d = (state_q == PEND);
  end

  // Registered interrupt and CPU output byte latch with one-cycle strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      interrupt <= 1'b0;
      out_data  <= '0;
      out_stb   <= 1'b0;
    end else begin
      interrupt <= irq_d;
      out_stb   <= cpu_wr;
      if (cpu_wr) out_data <= data_out;
    end
  end

endmodule
